spoke_sweep_sequencer: RTL
==========================

Name: spoke_sweep_sequencer

Overview:
- Drives a line-drawer client through a repeating radial "clock-hand" animation.
- For each of N_SPOKES endpoints around a fixed hub it runs: draw line (colour 1), dwell, erase the same line (colour 0), advance to the next spoke.
- Generalises the fixed 12-position cycler with:
  - parametrised spoke count and coordinate widths
  - a start/ready/done handshake to the drawer
  - a tick-based dwell
  - direction control, pause and a clean abort.

Parameters:
- X_W, 10, x coordinate width
- Y_W, 9, y coordinate width
- N_SPOKES, 12, number of spoke positions (2..64)
- HUB_X, 200, hub x coordinate
- HUB_Y, 200, hub y coordinate
- DWELL_W, 8, width of dwell counter

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- enable  in  1  run the sweep; low parks in IDLE after the current spoke completes
- dir  in  1  0 = clockwise (idx+1), 1 = counter-clockwise (idx-1); sampled in ADVANCE
- pause  in  1  freezes the dwell counter while high
- clear  in  1  abort request; sweep returns to spoke 0 with the screen clean
- tick  in  1  one-cycle dwell time base (e.g. frame strobe)
- dwell_len  in  DWELL_W  ticks to hold a drawn spoke; 0 = no hold
- line_ready  in  1  drawer idle and able to accept a line
- line_done  in  1  one-cycle pulse when the drawer has written the last pixel
- line_start  out  1  one-cycle request to the drawer
- x0, x1  out  X_W  line endpoints
- y0, y1  out  Y_W  line endpoints
- pixel_color  out  1  colour for the current line
- spoke_idx  out  $clog2(N_SPOKES)  current spoke
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset (async, active-low): state=IDLE, spoke_idx=0, line_start=0, pixel_color=0, dwell count=0, abort flag=0, busy=0. x0/y0 = hub, x1/y1 = spoke 0 endpoint.
- Endpoints: x0,y0 = HUB_X,HUB_Y; x1,y1 = table[spoke_idx]. Outputs are registered and stable from the REQ state until the matching line_done.
- IDLE: enable=1 and clear=0 → DRAW_REQ.
- DRAW_REQ: pixel_color=1. When line_ready=1, line_start pulses for exactly 1 cycle → DRAW_WAIT. With line_ready=0, stay in DRAW_REQ with no pulse.
- DRAW_WAIT: on line_done → DWELL, or → ERASE_REQ if the abort flag is set. Dwell count is loaded with dwell_len.
- DWELL: count decrements on tick when pause=0. Count==0 (including dwell_len=0) → ERASE_REQ in the next cycle.
- ERASE_REQ: pixel_color=0, same endpoints. Same line_ready/line_start rule as DRAW_REQ → ERASE_WAIT.
- ERASE_WAIT: on line_done → ADVANCE.
- ADVANCE (1 cycle):
  - If the abort flag is set, or enable=0: idx is set to 0 if aborting (else unchanged), abort flag cleared → IDLE.
  - Otherwise idx steps by dir with wrap: N_SPOKES-1 → 0 when dir=0; 0 → N_SPOKES-1 when dir=1. Then → DRAW_REQ.
- clear:
  - In IDLE: idx=0 immediately.
  - In any other state: sets the abort flag. An in-flight drawer line is never cut short.
  - In DWELL: jumps to ERASE_REQ next cycle.
  - Net effect: the drawn spoke is always erased before returning to IDLE.
- line_done outside a WAIT state is ignored. Simultaneous clear and line_done in DRAW_WAIT → ERASE_REQ.
- Exactly one line_start per REQ entry; no back-to-back starts.

Decomposition:
- Package sweep_pkg holds:
  - state enum (IDLE, DRAW_REQ, DRAW_WAIT, DWELL, ERASE_REQ, ERASE_WAIT, ADVANCE)
  - default 12-entry endpoint constants (radius 190 about 200,200)
  - a function returning endpoint x/y for an index
- One sub-module, spoke_table: combinational index → (x1,y1) lookup, parametrised by N_SPOKES and widths.

Test Plan:
- Reset release with enable=1, line_ready=1, dwell_len=0, drawer model (done 5 cycles after start) → sequence is:
  - start (color 1, x1,y1 = spoke 0)
  - start (color 0, same endpoints)
  - idx becomes 1

  After 12 spokes, idx wraps to 0.
- dir=1 from idx 0 → next idx 11, then 10.
- dwell_len=3, ticks every 4 cycles, pause asserted for 10 cycles mid-dwell → erase start is delayed by exactly the paused ticks.
- line_ready low for 7 cycles in DRAW_REQ → no line_start until ready, then a single 1-cycle pulse.
- clear at idx 5 during DWELL → erase of spoke 5 issued, then IDLE with idx=0, busy=0. clear coincident with line_done in DRAW_WAIT → same result.
- Async reset asserted mid-DRAW_WAIT → all outputs at reset values immediately, without waiting for a clock edge; no further line_start until reset is released.

Source files
------------

// File: rtl/spoke_sweep_sequencer_pkg.sv
// Shared types and the default 12-position spoke ring for the sweep sequencer.
// Endpoints sit on a radius-190 circle about (200,200), spoke 0 at 12 o'clock, clockwise.
package sweep_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRAW_REQ,
    S_DRAW_WAIT,
    S_DWELL,
    S_ERASE_REQ,
    S_ERASE_WAIT,
    S_ADVANCE
  } state_t;

  localparam int unsigned RING_N = 12;

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
  } endpoint_t;

  // Screen y grows downward, so the upper half of the ring has y < 200.
  function automatic endpoint_t spoke_endpoint(input logic [3:0] ring_idx);
    endpoint_t ep;
    case (ring_idx)
      4'd0:    ep = '{x: 16'd200, y: 16'd10};
      4'd1:    ep = '{x: 16'd295, y: 16'd35};
      4'd2:    ep = '{x: 16'd365, y: 16'd105};
      4'd3:    ep = '{x: 16'd390, y: 16'd200};
      4'd4:    ep = '{x: 16'd365, y: 16'd295};
      4'd5:    ep = '{x: 16'd295, y: 16'd365};
      4'd6:    ep = '{x: 16'd200, y: 16'd390};
      4'd7:    ep = '{x: 16'd105, y: 16'd365};
      4'd8:    ep = '{x: 16'd35,  y: 16'd295};
      4'd9:    ep = '{x: 16'd10,  y: 16'd200};
      4'd10:   ep = '{x: 16'd35,  y: 16'd105};
      4'd11:   ep = '{x: 16'd105, y: 16'd35};
      default: ep = '{x: 16'd200, y: 16'd200};
    endcase
    return ep;
  endfunction

endpackage

// File: rtl/spoke_sweep_sequencer_table.sv
// Combinational spoke index -> far endpoint lookup.
// Spoke counts other than 12 walk the same ring modulo 12.
module spoke_table
  import sweep_pkg::*;
#(
  parameter int N_SPOKES = 12,
  parameter int X_W      = 10,
  parameter int Y_W      = 9
) (
  input  logic [$clog2(N_SPOKES)-1:0] idx,
  output logic [X_W-1:0]              x1,
  output logic [Y_W-1:0]              y1
);

  logic [5:0] idx_wide;
  logic [3:0] ring_idx;
  endpoint_t  ep;

  always_comb begin
    idx_wide = 6'(idx);
    ring_idx = 4'(idx_wide % 6'(RING_N));
    ep       = spoke_endpoint(ring_idx);
    x1       = X_W'(ep.x);
    y1       = Y_W'(ep.y);
  end

endmodule

// File: rtl/spoke_sweep_sequencer.sv
// Radial clock-hand animator: draw a spoke, dwell, erase it, step to the next spoke.
// Talks to a line drawer through line_start / line_ready / line_done.
module spoke_sweep_sequencer
  import sweep_pkg::*;
#(
  parameter int X_W      = 10,
  parameter int Y_W      = 9,
  parameter int N_SPOKES = 12,
  parameter int HUB_X    = 200,
  parameter int HUB_Y    = 200,
  parameter int DWELL_W  = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        enable,
  input  logic                        dir,
  input  logic                        pause,
  input  logic                        clear,
  input  logic                        tick,
  input  logic [DWELL_W-1:0]          dwell_len,
  input  logic                        line_ready,
  input  logic                        line_done,
  output logic                        line_start,
  output logic [X_W-1:0]              x0,
  output logic [X_W-1:0]              x1,
  output logic [Y_W-1:0]              y0,
  output logic [Y_W-1:0]              y1,
  output logic                        pixel_color,
  output logic [$clog2(N_SPOKES)-1:0] spoke_idx,
  output logic                        busy
);

  localparam int               IDX_W    = $clog2(N_SPOKES);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_SPOKES - 1);
  localparam endpoint_t        EP0      = spoke_endpoint(4'd0);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic               abort_q, abort_d;
  logic               color_q, color_d;
  logic               start_q, start_d;
  logic               busy_q, busy_d;
  logic [X_W-1:0]     x1_q, tbl_x1;
  logic [Y_W-1:0]     y1_q, tbl_y1;
  logic               abort_req;

  // Endpoint follows the next index so x1/y1 are already valid on REQ entry.
  spoke_table #(
    .N_SPOKES (N_SPOKES),
    .X_W      (X_W),
    .Y_W      (Y_W)
  ) u_table (
    .idx (idx_d),
    .x1  (tbl_x1),
    .y1  (tbl_y1)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    dwell_d   = dwell_q;
    abort_d   = abort_q;
    color_d   = color_q;
    start_d   = 1'b0;
    abort_req = abort_q | clear;

    case (state_q)
      S_IDLE: begin
        if (clear) begin
          idx_d = '0;
        end else if (enable) begin
          state_d = S_DRAW_REQ;
          color_d = 1'b1;
        end
      end
      S_DRAW_REQ: begin
        abort_d = abort_req;
        if (line_ready) begin
          start_d = 1'b1;
          state_d = S_DRAW_WAIT;
        end
      end
      S_DRAW_WAIT: begin
        abort_d = abort_req;
        if (line_done) begin
          dwell_d = dwell_len;
          if (abort_req) begin
            state_d = S_ERASE_REQ;
            color_d = 1'b0;
          end else begin
            state_d = S_DWELL;
          end
        end
      end
      S_DWELL: begin
        abort_d = abort_req;
        if (abort_req || dwell_q == '0) begin
          state_d = S_ERASE_REQ;
          color_d = 1'b0;
        end else if (tick && !pause) begin
          dwell_d = dwell_q - DWELL_W'(1);
        end
      end
      S_ERASE_REQ: begin
        abort_d = abort_req;
        if (line_ready) begin
          start_d = 1'b1;
          state_d = S_ERASE_WAIT;
        end
      end
      S_ERASE_WAIT: begin
        abort_d = abort_req;
        if (line_done) state_d = S_ADVANCE;
      end
      S_ADVANCE: begin
        // The spoke is already erased here, so an abort only has to rewind the index.
        if (abort_req || !enable) begin
          abort_d = 1'b0;
          state_d = S_IDLE;
          if (abort_req) idx_d = '0;
        end else begin
          state_d = S_DRAW_REQ;
          color_d = 1'b1;
          if (!dir) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
          else      idx_d = (idx_q == '0) ? IDX_LAST : idx_q - IDX_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      dwell_q <= '0;
      abort_q <= 1'b0;
      color_q <= 1'b0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      x1_q    <= X_W'(EP0.x);
      y1_q    <= Y_W'(EP0.y);
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      dwell_q <= dwell_d;
      abort_q <= abort_d;
      color_q <= color_d;
      start_q <= start_d;
      busy_q  <= busy_d;
      x1_q    <= tbl_x1;
      y1_q    <= tbl_y1;
    end
  end

  assign x0          = X_W'(HUB_X);
  assign y0          = Y_W'(HUB_Y);
  assign x1          = x1_q;
  assign y1          = y1_q;
  assign line_start  = start_q;
  assign pixel_color = color_q;
  assign spoke_idx   = idx_q;
  assign busy        = busy_q;

endmodule
